pipe_rr_scheduler: RTL and testbench
====================================

// Module: pipe_rr_scheduler
// PURPOSE
//   Shares one WIDTH x SIZE register pipeline (no reset, no stall, no valid;
//   latency SIZE+1 clocks datain->dataout) between NREQ requesters.
//   - Round-robin arbitration, at most one issue per clock.
//   - Carries a valid+tag shadow pipeline alongside the data.
//   - Issue is gated by downstream credits, so the stall-free pipeline can never overrun its sink.
// PARAMETERS
//   WIDTH    16  data width of each requester and of the shared pipeline
//   SIZE     8   stage count of the shared pipeline; PIPE_LAT = SIZE+1
//   NREQ     4   number of requesters (>=2); TAGW = $clog2(NREQ)
//   CREDITS  8   downstream buffer slots (1..255); credit counter is 8 bits
// PORTS
//   clk            in   1           single clock, all logic on posedge
//   rst_n          in   1           asynchronous active-low reset
//   sched_en       in   1           1 = grants allowed; 0 = no new issues, in-flight drains
//   req_valid      in   NREQ        requester i has a word pending
//   req_data       in   NREQ*WIDTH  word i in bits [i*WIDTH +: WIDTH]; held while valid & !ready
//   req_ready      out  NREQ        one-hot grant; transfer = req_valid[i] & req_ready[i]
//   pipe_datain    out  WIDTH       to shared pipeline datain
//   pipe_dataout   in   WIDTH       from shared pipeline dataout
//   out_valid      out  1           pipe_dataout holds a real word this cycle
//   out_tag        out  TAGW        requester index of that word
//   out_data       out  WIDTH       = pipe_dataout (combinational passthrough)
//   credit_return  in   1           1-clock pulse: downstream freed one slot
//   credit_count   out  8           credits currently available
//   err_credit_ovf out  1           sticky: credit_return seen with credit_count == CREDITS
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - rr_ptr = 0; credit_count = CREDITS; err_credit_ovf = 0.
//     - Every shadow stage valid = 0, tag = 0; so out_valid = 0 and out_tag = 0.
//     - Stale pipeline data is masked by out_valid = 0.
//     - A mid-operation reset discards all in-flight words and their credits.
//   Arbitration (combinational per cycle):
//     - issue = sched_en & (credit_count != 0) & |req_valid.
//     - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//     - req_ready[winner] = issue; all other bits 0. req_ready never depends on
//       req_data, and is 0 for requesters with valid low.
//     - On issue: rr_ptr <= (winner+1) mod NREQ. Otherwise rr_ptr holds.
//   Datapath:
//     - pipe_datain = req_data[winner] when issue, else 0.
//     - The pipeline samples pipe_datain on the same edge that completes the handshake.
//   Shadow pipeline (PIPE_LAT stages of {valid, tag}):
//     - stage0 <= {issue, winner}; stage[k] <= stage[k-1]; shifts every clock, never stalls.
//     - out_valid/out_tag = stage[PIPE_LAT-1].
//     - A word issued at edge E appears on out_data with out_valid = 1 in the cycle
//       after edge E+SIZE, i.e. the data is captured PIPE_LAT edges later.
//   Credits:
//     - issue only:          credit_count - 1.
//     - credit_return only:  credit_count + 1, saturating at CREDITS.
//     - Both in one cycle:   unchanged.
//     - credit_count == 0:   no grants; pending requests wait, rr_ptr frozen.
//     - credit_return at CREDITS with no issue: count holds, err_credit_ovf <= 1
//       until reset.
//   sched_en = 0: no grants; shadow pipeline and credits keep operating; drains in PIPE_LAT clocks.
//   Throughput: 1 word/clock while credits remain. A single requester may issue back-to-back.
// TESTING
//   1. Reset with all req_valid = 1 -> req_ready = 0 while rst_n = 0; after release
//      credit_count = 8, out_valid = 0 for 9 clocks, err_credit_ovf = 0.
//   2. Only req 2 valid, data 16'hA5A5, one clock -> req_ready = 4'b0100; out_valid = 1,
//      out_tag = 2, out_data = 16'hA5A5 exactly PIPE_LAT = 9 edges later; credit_count = 7.
//   3. All 4 requesters valid continuously, credit_return every clock -> grants
//      0,1,2,3,0,... one per clock; outputs tagged 0,1,2,3 in order; credit_count stays 8.
//   4. All valid, no credit_return -> exactly 8 issues, then req_ready = 0.
//      One credit_return pulse -> exactly 1 more issue, to the next requester in rotation.
//   5. credit_return pulse at credit_count = 8 -> count stays 8, err_credit_ovf = 1 and sticky.
//      Issue and return in the same clock -> count unchanged.
//   6. Issue 3 words, assert rst_n = 0 for 1 clock mid-flight -> out_valid never rises
//      for them, credit_count = 8. sched_en = 0 with requests pending -> no req_ready.

Source files
------------

// File: rtl/pipe_rr_scheduler.sv
// Round-robin scheduler that shares one stall-free WIDTH x SIZE register
// pipeline between NREQ requesters. A {valid, tag} shadow pipeline runs
// alongside the external data pipeline so each word leaves tagged with its
// requester. Issue is gated by downstream credits so the pipeline can never
// overrun its sink.
module pipe_rr_scheduler #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 8,
  parameter int NREQ    = 4,
  parameter int CREDITS = 8,
  localparam int TAGW     = $clog2(NREQ),
  localparam int PIPE_LAT = SIZE + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sched_en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      pipe_datain,
  input  logic [WIDTH-1:0]      pipe_dataout,
  output logic                  out_valid,
  output logic [TAGW-1:0]       out_tag,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  credit_return,
  output logic [7:0]            credit_count,
  output logic                  err_credit_ovf
);

  localparam logic [7:0] CRED_MAX = 8'(CREDITS);

  logic [TAGW-1:0] r_rr_ptr;
  logic [7:0]      r_credit;
  logic            r_err_ovf;
  logic            r_vld_p [PIPE_LAT];
  logic [TAGW-1:0] r_tag_p [PIPE_LAT];

  logic            w_found;
  logic [TAGW-1:0] w_winner;
  logic            w_issue;
  int              w_idx;

  // Credit increment that never exceeds the downstream buffer depth.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= CRED_MAX) ? CRED_MAX : c + 8'd1;
  endfunction

  // Next round-robin start position after granting requester w.
  function automatic logic [TAGW-1:0] rr_next(input logic [TAGW-1:0] w);
    return (w == TAGW'(NREQ - 1)) ? '0 : w + TAGW'(1);
  endfunction

  // Find the first valid requester at or after the round-robin pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found) begin
        w_idx = (int'(r_rr_ptr) + j) % NREQ;
        if (req_valid[w_idx]) begin
          w_found  = 1'b1;
          w_winner = TAGW'(w_idx);
        end
      end
    end
  end

  // Grant only out of reset, when enabled, with a credit in hand and a request pending.
  assign w_issue     = rst_n & sched_en & (r_credit != 8'd0) & w_found;
  assign req_ready   = w_issue ? (NREQ'(1) << w_winner) : '0;
  assign pipe_datain = w_issue ? req_data[int'(w_winner)*WIDTH +: WIDTH] : '0;

  // Round-robin pointer advances past the winner on every issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= rr_next(w_winner);
    end
  end

  // Credit counter and sticky overflow flag; issue and return together cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit  <= CRED_MAX;
      r_err_ovf <= 1'b0;
    end else begin
      case ({w_issue, credit_return})
        2'b10:   r_credit <= r_credit - 8'd1;
        2'b01:   r_credit <= sat_inc(r_credit);
        default: r_credit <= r_credit;
      endcase
      if (credit_return && !w_issue && (r_credit == CRED_MAX)) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  // Shadow {valid, tag} pipeline: shifts every clock in lockstep with the data pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        r_vld_p[k] <= 1'b0;
        r_tag_p[k] <= '0;
      end
    end else begin
      r_vld_p[0] <= w_issue;
      r_tag_p[0] <= w_issue ? w_winner : '0;
      for (int k = 1; k < PIPE_LAT; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
        r_tag_p[k] <= r_tag_p[k-1];
      end
    end
  end

  // --- output stage: last shadow stage qualifies the pipeline output ---
  assign out_valid      = r_vld_p[PIPE_LAT-1];
  assign out_tag        = r_tag_p[PIPE_LAT-1];
  assign out_data       = pipe_dataout;
  assign credit_count   = r_credit;
  assign err_credit_ovf = r_err_ovf;

endmodule

// File: tb/tb_pipe_rr_scheduler.sv
// Bench for pipe_rr_scheduler: models the external 9-register data pipeline,
// drives directed request/credit vectors, and scores every tagged output word
// against a queue of expected {tag, data, arrival cycle} entries.
module tb_pipe_rr_scheduler;
  localparam int WIDTH    = 16;
  localparam int SIZE     = 8;
  localparam int NREQ     = 4;
  localparam int CREDITS  = 8;
  localparam int PIPE_LAT = SIZE + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_en;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] pipe_datain;
  logic [15:0] pipe_dataout;
  logic        out_valid;
  logic [1:0]  out_tag;
  logic [15:0] out_data;
  logic        credit_return;
  logic [7:0]  credit_count;
  logic        err_credit_ovf;

  pipe_rr_scheduler #(.WIDTH(WIDTH), .SIZE(SIZE), .NREQ(NREQ), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_datain(pipe_datain), .pipe_dataout(pipe_dataout),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data),
    .credit_return(credit_return), .credit_count(credit_count),
    .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  // Shared data pipeline: PIPE_LAT plain registers, no reset.
  logic [15:0] pipe_q [PIPE_LAT];
  always @(posedge clk) begin
    pipe_q[0] <= pipe_datain;
    for (int k = 1; k < PIPE_LAT; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign pipe_dataout = pipe_q[PIPE_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  tag;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_chk = 0;
  int n_bad = 0;
  int seq   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mkdata();
    logic [11:0] s;
    s = 12'(seq);
    seq++;
    return {4'h3, s, 4'h2, s, 4'h1, s, 4'h0, s};
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: every qualified output word must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("out_valid_unexpected", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_tag", 32'(out_tag), 32'(e.tag));
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // One clock of stimulus; a grant pushes the expected output word.
  task automatic step(input logic [3:0] v, input logic ret, input logic en,
                      input logic [3:0] exp_rdy, input string name,
                      input logic [63:0] d = 64'd0);
    exp_t x;
    int   i;
    @(negedge clk);
    req_valid     = v;
    credit_return = ret;
    sched_en      = en;
    req_data      = (d != 64'd0) ? d : mkdata();
    #1;
    check({name, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'd0) begin
      i = oh_idx(exp_rdy);
      x.tag  = 2'(i);
      x.data = req_data[i*16 +: 16];
      x.due  = cyc + PIPE_LAT;
      sb.push_back(x);
      check({name, "_datain"}, 32'(pipe_datain), 32'(x.data));
    end
  endtask

  task automatic apply_reset(input int n);
    req_valid     = 4'd0;
    credit_return = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    repeat (n) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every requester asking: no grants while held.
    rst_n         = 1'b0;
    sched_en      = 1'b1;
    req_valid     = 4'hF;
    req_data      = 64'd0;
    credit_return = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("t1_ready_in_reset", 32'(req_ready), 32'd0);
      check("t1_credit_in_reset", 32'(credit_count), 32'd8);
      check("t1_valid_in_reset", 32'(out_valid), 32'd0);
      check("t1_tag_in_reset", 32'(out_tag), 32'd0);
    end
    req_valid = 4'd0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(4'd0, 1'b0, 1'b1, 4'd0, "t1_idle");
      check("t1_out_valid", 32'(out_valid), 32'd0);
      check("t1_credit", 32'(credit_count), 32'd8);
      check("t1_err", 32'(err_credit_ovf), 32'd0);
    end

    // Single word from requester 2.
    step(4'b0100, 1'b0, 1'b1, 4'b0100, "t2_issue", {16'h0, 16'hA5A5, 32'h0});
    step(4'd0, 1'b0, 1'b1, 4'd0, "t2_idle");
    check("t2_credit", 32'(credit_count), 32'd7);
    repeat (10) step(4'd0, 1'b0, 1'b1, 4'd0, "t2_drain");
    step(4'd0, 1'b1, 1'b1, 4'd0, "t2_ret");
    step(4'd0, 1'b0, 1'b1, 4'd0, "t2_after");
    check("t2_credit_back", 32'(credit_count), 32'd8);

    // Full rotation with a credit returned every clock.
    apply_reset(1);
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 1'b1, 1'b1, 4'(1 << (i % 4)), "t3_rr");
      check("t3_credit", 32'(credit_count), 32'd8);
    end
    step(4'd0, 1'b0, 1'b1, 4'd0, "t3_end");
    check("t3_credit_end", 32'(credit_count), 32'd8);

    // Credit exhaustion, then one returned credit buys one issue.
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 1'b0, 1'b1, 4'(1 << (i % 4)), "t4_burst");
      check("t4_credit", 32'(credit_count), 32'(8 - i));
    end
    repeat (3) begin
      step(4'hF, 1'b0, 1'b1, 4'd0, "t4_starved");
      check("t4_credit_zero", 32'(credit_count), 32'd0);
    end
    step(4'hF, 1'b1, 1'b1, 4'd0, "t4_ret");
    step(4'hF, 1'b0, 1'b1, 4'b0001, "t4_one");
    check("t4_credit_one", 32'(credit_count), 32'd1);
    step(4'hF, 1'b0, 1'b1, 4'd0, "t4_after");
    check("t4_credit_again_zero", 32'(credit_count), 32'd0);
    repeat (8) step(4'd0, 1'b1, 1'b1, 4'd0, "t4_refill");
    step(4'd0, 1'b0, 1'b1, 4'd0, "t4_full");
    check("t4_credit_full", 32'(credit_count), 32'd8);
    check("t4_err", 32'(err_credit_ovf), 32'd0);

    // Return while full: saturate and raise the sticky error.
    step(4'd0, 1'b1, 1'b1, 4'd0, "t5_ovf");
    step(4'd0, 1'b0, 1'b1, 4'd0, "t5_idle");
    check("t5_credit_sat", 32'(credit_count), 32'd8);
    check("t5_err_set", 32'(err_credit_ovf), 32'd1);
    repeat (3) step(4'd0, 1'b0, 1'b1, 4'd0, "t5_hold");
    check("t5_err_sticky", 32'(err_credit_ovf), 32'd1);
    step(4'b0010, 1'b1, 1'b1, 4'b0010, "t5_both");
    step(4'd0, 1'b0, 1'b1, 4'd0, "t5_after");
    check("t5_credit_both", 32'(credit_count), 32'd8);
    check("t5_err_still", 32'(err_credit_ovf), 32'd1);

    // Mid-flight reset discards words and credits; then sched_en gating.
    step(4'hF, 1'b0, 1'b1, 4'b0100, "t6_issue");
    step(4'hF, 1'b0, 1'b1, 4'b1000, "t6_issue");
    step(4'hF, 1'b0, 1'b1, 4'b0001, "t6_issue");
    apply_reset(1);
    for (int i = 0; i < 12; i++) begin
      step(4'd0, 1'b0, 1'b1, 4'd0, "t6_flushed");
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_credit", 32'(credit_count), 32'd8);
    end
    check("t6_err_cleared", 32'(err_credit_ovf), 32'd0);
    repeat (4) begin
      step(4'hF, 1'b0, 1'b0, 4'd0, "t6_disabled");
      check("t6_credit_dis", 32'(credit_count), 32'd8);
    end
    step(4'hF, 1'b0, 1'b1, 4'b0001, "t6_enable");
    repeat (11) step(4'd0, 1'b0, 1'b1, 4'd0, "t6_drain");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
